// File: rtl/rat_io_pkg.sv
// ============================================================================
// Module  : rat_io_pkg
// Brief   : RAT MCU I/O port map and button debounce state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rat_io_pkg;

    localparam logic [7:0] SWITCHES_ID = 8'h20;
    localparam logic [7:0] LEDS_ID     = 8'h40;
    localparam logic [7:0] BTN_CNT_ID  = 8'h21;
    localparam logic [7:0] BTN_ACK_ID  = 8'h41;
    localparam logic [7:0] BTN_MASK_ID = 8'h42;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : Two-flop synchronizer plus debounce FSM emitting a one-cycle PRESS.
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce
    import rat_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic BTN,
    output logic PRESS
);

    localparam int              CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   C_CNT_ONE = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_sync_vld;
    logic          r_armed;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;

    db_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_armed_nxt;
    logic          w_press;

    // Until r_armed is set, a debounced low must be seen before a press can
    // fire, so a button still held across reset produces no event.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_armed_nxt = r_armed;
        w_press     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_armed) begin
                    if (r_sync_vld[1]) begin
                        if (r_sync2) begin
                            w_state_nxt = HELD;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == C_CNT_MAX) begin
                            w_armed_nxt = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + C_CNT_ONE;
                        end
                    end
                end else if (r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_armed_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
            r_state    <= IDLE;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= BTN;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_armed    <= w_armed_nxt;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign PRESS = w_press;

endmodule

`default_nettype wire

// File: rtl/rat_btn_intr_ctrl.sv
// ============================================================================
// Module  : rat_btn_intr_ctrl
// Brief   : Debounced button -> pending interrupt with software ack and an
//           8-bit press counter. Optional mask via RAT_BTN_INTR_MASK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rat_btn_intr_ctrl
    import rat_io_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] CNT_ID          = BTN_CNT_ID,
    parameter logic [7:0] ACK_ID          = BTN_ACK_ID
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BTN,
    input  logic [7:0] PORT_ID,
    input  logic       IO_STRB,
    input  logic [7:0] OUT_PORT,
    output logic       INTR,
    output logic [7:0] CNT_DATA
);

    logic       w_press;
    logic       w_ack;
    logic [7:0] r_press_cnt;
    logic       r_pending;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .BTN    (BTN),
        .PRESS  (w_press)
    );

    assign w_ack = IO_STRB && (PORT_ID == ACK_ID);

    // A press in the same cycle as an ack keeps the interrupt pending.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_press_cnt <= 8'h00;
            r_pending   <= 1'b0;
        end else begin
            if (w_press) begin
                r_press_cnt <= r_press_cnt + 8'h01;
            end
            if (w_press) begin
                r_pending <= 1'b1;
            end else if (w_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef RAT_BTN_INTR_MASK_EN
    logic r_mask;
    logic w_mask_wr;

    assign w_mask_wr = IO_STRB && (PORT_ID == BTN_MASK_ID);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mask <= 1'b1;
        end else if (w_mask_wr) begin
            r_mask <= OUT_PORT[0];
        end
    end

    assign INTR = r_pending & r_mask;

    always_comb begin
        CNT_DATA = 8'h00;
        if (PORT_ID == CNT_ID) begin
            CNT_DATA = r_press_cnt;
        end else if (PORT_ID == BTN_MASK_ID) begin
            CNT_DATA = {7'b0, r_mask};
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, OUT_PORT[7:1]};
`else
    assign INTR = r_pending;

    always_comb begin
        CNT_DATA = 8'h00;
        if (PORT_ID == CNT_ID) begin
            CNT_DATA = r_press_cnt;
        end
    end

    // Ack data is don't-care, so the output bus is not otherwise consumed.
    logic w_unused;
    assign w_unused = &{1'b0, OUT_PORT};
`endif

endmodule

`default_nettype wire

// File: doc/rat_btn_intr_ctrl.md
Name: rat_btn_intr_ctrl

Overview:
- Upstream I/O peripheral for the RAT MCU on Basys3. It turns a raw pushbutton into a debounced press event.
- Each event latches a pending interrupt that drives the MCU interrupt line. The interrupt stays high until software acknowledges it with an OUT to an ack port.
- Keeps an 8-bit press counter that software reads with IN through the wrapper's input mux.
- Connects directly to the MCU's PORT_ID, IO_STRB and OUT_PORT bus.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized-high cycles that qualify a press (5 ms at 100 MHz); legal values ≥ 2.
- CNT_ID, 8'h21, input port ID that returns the press count.
- ACK_ID, 8'h41, output port ID whose write clears the pending interrupt.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- BTN  in  1  raw, asynchronous pushbutton level (active-high).
- PORT_ID  in  8  MCU port ID.
- IO_STRB  in  1  MCU output strobe.
- OUT_PORT  in  8  MCU output data; value is ignored for the ack.
- INTR  out  1  interrupt request to the MCU INTERUPT pin.
- CNT_DATA  out  8  press count when PORT_ID==CNT_ID, else 8'h00; the wrapper ORs this into its input mux.

Behaviour:
- Reset (RESET_N low, asynchronous): all registers clear.
  - sync1 = sync2 = 0, state = IDLE, debounce counter = 0, press_cnt = 0, pending = 0.
  - Outputs: INTR = 0; CNT_DATA = 0 unless PORT_ID==CNT_ID, in which case it reads 0.
  - Reset asserted mid-debounce or while pending aborts everything. After release, a still-held BTN must go low (debounced) and high again before a new event.
- Synchronizer: BTN → sync1 → sync2, two flops. Only sync2 is used downstream.
- Debounce FSM, counter width $clog2(DEBOUNCE_CYCLES):
  - IDLE:
    - sync2=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT:
    - sync2=0 → IDLE, cnt=0.
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 → HELD, cnt=0, fire press event.
    - Otherwise cnt++.
  - HELD:
    - sync2=0 → RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT:
    - sync2=1 → HELD, cnt=0.
    - sync2=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE, cnt=0.
    - Otherwise cnt++.
  - The press event is a single-cycle internal pulse, fired on the PRESS_WAIT→HELD transition only. Release never generates an event.
- Latency: BTN is first captured into sync1 at edge k. press_cnt increments and pending sets at edge k+1+DEBOUNCE_CYCLES. INTR is high immediately after that edge.
- press_cnt: increments by 1 on each event and wraps 8'hFF → 8'h00. Software cannot write it.
- pending:
  - Set on an event.
  - Cleared on any cycle with IO_STRB=1 and PORT_ID==ACK_ID.
  - An event and an ack in the same cycle leave pending=1 (event wins); press_cnt still increments.
  - The ack is idempotent. A strobe held for several CLK cycles (the MCU runs at CLK/2) is legal.
  - An ack while pending=0 has no effect.
- INTR = pending, registered, with no combinational path from inputs.
- CNT_DATA is combinational from PORT_ID and press_cnt, so it has zero latency on the read.
- Multiple events before an ack collapse into one pending interrupt. press_cnt still records every event.

Optional Feature:
- Macro: RAT_BTN_INTR_MASK_EN.
- When defined:
  - Adds an interrupt-mask register, reset value 1, written by IO_STRB=1 && PORT_ID==8'h42 with mask ← OUT_PORT[0].
  - INTR = pending & mask, still from registers.
  - pending keeps latching while masked, so unmasking with pending=1 raises INTR the next cycle.
  - ID 8'h42 is readable through CNT_DATA's mux and returns {7'b0, mask}.
- When undefined: no mask register, INTR = pending, and port ID 8'h42 is ignored.

Decomposition:
- Package rat_io_pkg:
  - Port-ID constants: SWITCHES_ID=8'h20, LEDS_ID=8'h40, BTN_CNT_ID=8'h21, BTN_ACK_ID=8'h41, BTN_MASK_ID=8'h42.
  - typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports CLK, RESET_N, BTN, PRESS):
  - Contains the synchronizer, counter and FSM.
  - PRESS is a one-cycle pulse.
- The top level holds press_cnt, pending, the optional mask and the port decode.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset/idle: RESET_N low then high, BTN=0, PORT_ID=8'h21 → INTR=0, CNT_DATA=8'h00.
- Clean press: BTN rises before edge k and holds → INTR rises after edge k+5, CNT_DATA=8'h01. A second read at PORT_ID=8'h20 gives CNT_DATA=8'h00.
- Bounce: BTN toggles 1,0,1,0 on successive cycles, then stays high for 6 cycles → exactly one event, press_cnt=1. A glitch of 3 cycles or fewer alone → no event.
- Ack handshake:
  - With INTR=1, drive IO_STRB=1, PORT_ID=8'h41 for 2 cycles → INTR=0 on the cycle after the first strobe edge.
  - Ack while INTR=0 → no change.
- Simultaneous event and ack: align the strobe with the event edge → INTR stays 1 and press_cnt increments. A 256-press sequence wraps press_cnt to 8'h00.
- Reset mid-operation: assert RESET_N low during PRESS_WAIT and separately while pending=1 → INTR=0 and press_cnt=0 immediately. A still-held BTN after release gives no event until it is released and pressed again.
